// File: rtl/pipe_mux.sv
// N-way channel multiplexer with an optional select register, a configurable
// output pipeline, a valid chain aligned with the data and a sticky out-of-range flag.
module pipe_mux #(
    parameter int  WIDTH    = 18,
    parameter int  INPUTS   = 4,
    parameter int  PIPE     = 1,
    parameter int  SELREG   = 1,
    parameter int  OOR_MODE = 0,
    localparam int SELW     = ($clog2(INPUTS) > 1) ? $clog2(INPUTS) : 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CE,
    input  logic [WIDTH*INPUTS-1:0] in_bus,
    input  logic [SELW-1:0]         sel,
    input  logic                    in_valid,
    input  logic                    err_clr,
    output logic [WIDTH-1:0]        dout,
    output logic                    dout_valid,
    output logic                    sel_err
);

    localparam logic [SELW:0] LIMIT = (SELW + 1)'(INPUTS);

    // Handshake: valid only, no back-pressure. in_valid qualifies in_bus/sel of the
    // same cycle; dout_valid=1 marks the dout produced by that input cycle.
    logic [SELW-1:0]  sel_eff;
    logic             valid_s;
    logic             sel_oor;
    logic [WIDTH-1:0] mux_y;
    logic [WIDTH-1:0] last_good;

    generate
        if (SELREG != 0) begin : g_selreg
            logic [SELW-1:0] sel_q;
            logic            valid_q;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    sel_q   <= '0;
                    valid_q <= 1'b0;
                end else if (CE) begin
                    sel_q   <= sel;
                    valid_q <= in_valid;
                end
            end

            assign sel_eff = sel_q;
            assign valid_s = valid_q;
        end else begin : g_selcomb
            assign sel_eff = sel;
            assign valid_s = in_valid;
        end
    endgenerate

    assign sel_oor = ({1'b0, sel_eff} >= LIMIT);

    always_comb begin
        mux_y = '0;
        if (sel_oor) begin
            if (OOR_MODE != 0) begin
                mux_y = last_good;
            end
        end else begin
            mux_y = in_bus[int'(sel_eff) * WIDTH +: WIDTH];
        end
    end

    // Tracks the latest in-range result regardless of in_valid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_good <= '0;
        end else if (CE && !sel_oor) begin
            last_good <= mux_y;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sel_err <= 1'b0;
        end else if (CE) begin
            if (valid_s && sel_oor) begin
                sel_err <= 1'b1;
            end else if (err_clr) begin
                sel_err <= 1'b0;
            end
        end
    end

    generate
        if (PIPE == 0) begin : g_nopipe
            assign dout       = mux_y;
            assign dout_valid = valid_s;
        end else begin : g_pipe
            logic [WIDTH-1:0] data_q [PIPE];
            logic [PIPE-1:0]  vld_q;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    for (int i = 0; i < PIPE; i++) begin
                        data_q[i] <= '0;
                    end
                    vld_q <= '0;
                end else if (CE) begin
                    data_q[0] <= mux_y;
                    vld_q[0]  <= valid_s;
                    for (int i = 1; i < PIPE; i++) begin
                        data_q[i] <= data_q[i-1];
                        vld_q[i]  <= vld_q[i-1];
                    end
                end
            end

            assign dout       = data_q[PIPE-1];
            assign dout_valid = vld_q[PIPE-1];
        end
    endgenerate

endmodule

// File: tb/tb_pipe_mux.sv
// Bench for pipe_mux: three configurations share one stimulus stream; expected
// outputs are queued at issue time and a negedge monitor pops and compares them.
module tb_pipe_mux;

    localparam int W     = 18;
    localparam int LAT_A = 3;  // INPUTS=4, SELREG=1, PIPE=2, OOR_MODE=0
    localparam int LAT_B = 4;  // INPUTS=5, SELREG=1, PIPE=3, OOR_MODE=1
    localparam int LAT_C = 1;  // INPUTS=5, SELREG=0, PIPE=1, OOR_MODE=0

    logic           CLK;
    logic           RST;
    logic           CE;
    logic [5*W-1:0] in_bus;
    logic [2:0]     sel;
    logic           in_valid;
    logic           err_clr;

    logic [W-1:0] dout_w [3];
    logic         dv_w   [3];
    logic         err_w  [3];

    logic [W-1:0] exp_q [3][$];
    int           due_q [3][$];
    string        nm [3] = '{"a", "b", "c"};

    int   checks = 0;
    int   passes = 0;
    int   ce_cnt = 0;
    logic last_ce = 1'b0;

    pipe_mux #(.WIDTH(W), .INPUTS(4), .PIPE(2), .SELREG(1), .OOR_MODE(0)) u_a (
        .CLK(CLK), .RST(RST), .CE(CE), .in_bus(in_bus[4*W-1:0]), .sel(sel[1:0]),
        .in_valid(in_valid), .err_clr(err_clr),
        .dout(dout_w[0]), .dout_valid(dv_w[0]), .sel_err(err_w[0])
    );

    pipe_mux #(.WIDTH(W), .INPUTS(5), .PIPE(3), .SELREG(1), .OOR_MODE(1)) u_b (
        .CLK(CLK), .RST(RST), .CE(CE), .in_bus(in_bus), .sel(sel),
        .in_valid(in_valid), .err_clr(err_clr),
        .dout(dout_w[1]), .dout_valid(dv_w[1]), .sel_err(err_w[1])
    );

    pipe_mux #(.WIDTH(W), .INPUTS(5), .PIPE(1), .SELREG(0), .OOR_MODE(0)) u_c (
        .CLK(CLK), .RST(RST), .CE(CE), .in_bus(in_bus), .sel(sel),
        .in_valid(in_valid), .err_clr(err_clr),
        .dout(dout_w[2]), .dout_valid(dv_w[2]), .sel_err(err_w[2])
    );

    // Clock and enabled-edge counter
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        last_ce <= CE;
        ce_cnt  <= ce_cnt + (CE ? 1 : 0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: only edges with CE=1 can move the pipeline
    task automatic mon(input int u);
        logic [W-1:0] e;
        int           t;
        if (dv_w[u]) begin
            if (exp_q[u].size() == 0) begin
                checks++;
                $display("FAIL %s_spurious: dout_valid=1 dout=0x%0h, expected no output", nm[u], dout_w[u]);
            end else begin
                e = exp_q[u].pop_front();
                t = due_q[u].pop_front();
                chk({nm[u], "_data"}, 32'(dout_w[u]), 32'(e));
                chk({nm[u], "_latency"}, 32'(ce_cnt), 32'(t));
            end
        end else if (due_q[u].size() > 0 && due_q[u][0] <= ce_cnt) begin
            checks++;
            $display("FAIL %s_missing: dout_valid=0 at cycle %0d, expected data 0x%0h", nm[u], ce_cnt, exp_q[u][0]);
            void'(exp_q[u].pop_front());
            void'(due_q[u].pop_front());
        end
    endtask

    always @(negedge CLK) begin
        if (!RST && last_ce) begin
            for (int u = 0; u < 3; u++) begin
                mon(u);
            end
        end
    end

    // Driver tasks: called at a negedge, drive one cycle, return at the next negedge
    task automatic step(input logic [2:0] s, input logic v, input logic clr, input logic ce_i,
                        input logic [W-1:0] ea, input logic [W-1:0] eb, input logic [W-1:0] ec);
        sel      = s;
        in_valid = v;
        err_clr  = clr;
        CE       = ce_i;
        if (v && ce_i) begin
            exp_q[0].push_back(ea); due_q[0].push_back(ce_cnt + LAT_A);
            exp_q[1].push_back(eb); due_q[1].push_back(ce_cnt + LAT_B);
            exp_q[2].push_back(ec); due_q[2].push_back(ce_cnt + LAT_C);
        end
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        repeat (n) step(3'd0, 1'b0, 1'b0, 1'b1, '0, '0, '0);
    endtask

    task automatic set_ch(input int k, input logic [W-1:0] val);
        in_bus[k*W +: W] = val;
    endtask

    task automatic chk_err(input string tag, input logic ea, input logic eb, input logic ec);
        chk({tag, "_a"}, 32'(err_w[0]), 32'(ea));
        chk({tag, "_b"}, 32'(err_w[1]), 32'(eb));
        chk({tag, "_c"}, 32'(err_w[2]), 32'(ec));
    endtask

    task automatic chk_zero(input string tag);
        for (int u = 0; u < 3; u++) begin
            chk({tag, "_dout_", nm[u]}, 32'(dout_w[u]), 32'd0);
            chk({tag, "_valid_", nm[u]}, 32'(dv_w[u]), 32'd0);
            chk({tag, "_err_", nm[u]}, 32'(err_w[u]), 32'd0);
        end
    endtask

    initial begin
        RST      = 1'b1;
        CE       = 1'b1;
        sel      = '0;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        in_bus   = '0;
        for (int k = 0; k < 5; k++) set_ch(k, W'(18'h100 + k));

        repeat (2) @(negedge CLK);
        chk_zero("reset");
        RST = 1'b0;

        // Every channel in turn; a (4 channels) sees only sel[1:0]
        step(3'd0, 1'b1, 1'b0, 1'b1, 18'h100, 18'h100, 18'h100);
        step(3'd1, 1'b1, 1'b0, 1'b1, 18'h101, 18'h101, 18'h101);
        step(3'd2, 1'b1, 1'b0, 1'b1, 18'h102, 18'h102, 18'h102);
        step(3'd3, 1'b1, 1'b0, 1'b1, 18'h103, 18'h103, 18'h103);
        step(3'd4, 1'b1, 1'b0, 1'b1, 18'h100, 18'h104, 18'h104);
        idle(6);

        // Out-of-range selects: b holds 0xABC, c substitutes zero
        set_ch(2, 18'hABC);
        step(3'd2, 1'b1, 1'b0, 1'b1, 18'hABC, 18'hABC, 18'hABC);
        step(3'd6, 1'b1, 1'b0, 1'b1, 18'hABC, 18'hABC, 18'h000);
        step(3'd7, 1'b1, 1'b0, 1'b1, 18'h103, 18'hABC, 18'h000);
        idle(6);
        chk_err("err_set", 1'b0, 1'b1, 1'b1);
        idle(3);
        chk_err("err_sticky", 1'b0, 1'b1, 1'b1);
        step(3'd0, 1'b0, 1'b1, 1'b1, '0, '0, '0);
        chk_err("err_clr", 1'b0, 1'b0, 1'b0);

        // Out-of-range select without in_valid leaves the flag alone
        step(3'd7, 1'b0, 1'b0, 1'b1, '0, '0, '0);
        step(3'd7, 1'b0, 1'b0, 1'b1, '0, '0, '0);
        idle(2);
        chk_err("err_invalid_oor", 1'b0, 1'b0, 1'b0);

        // Clear and a new error in the same cycle: set wins
        step(3'd6, 1'b1, 1'b1, 1'b1, 18'hABC, 18'h100, 18'h000);
        step(3'd6, 1'b1, 1'b1, 1'b1, 18'hABC, 18'h100, 18'h000);
        chk_err("err_set_wins", 1'b0, 1'b1, 1'b1);
        idle(6);

        // Clock-enable freeze mid-stream; the garbage inputs must not be captured
        step(3'd0, 1'b1, 1'b0, 1'b1, 18'h100, 18'h100, 18'h100);
        step(3'd1, 1'b1, 1'b0, 1'b1, 18'h101, 18'h101, 18'h101);
        step(3'd2, 1'b1, 1'b0, 1'b1, 18'hABC, 18'hABC, 18'hABC);
        repeat (4) step(3'd1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        step(3'd3, 1'b1, 1'b0, 1'b1, 18'h103, 18'h103, 18'h103);
        step(3'd4, 1'b1, 1'b0, 1'b1, 18'h100, 18'h104, 18'h104);
        idle(6);

        // Reset pulse between edges with data in flight
        step(3'd1, 1'b1, 1'b0, 1'b1, 18'h101, 18'h101, 18'h101);
        step(3'd2, 1'b1, 1'b0, 1'b1, 18'hABC, 18'hABC, 18'hABC);
        step(3'd3, 1'b1, 1'b0, 1'b1, 18'h103, 18'h103, 18'h103);
        #2;
        RST      = 1'b1;
        in_valid = 1'b0;
        sel      = '0;
        #1;
        chk_zero("rst_pulse");
        for (int u = 0; u < 3; u++) begin
            exp_q[u].delete();
            due_q[u].delete();
        end
        #1;
        RST = 1'b0;
        @(negedge CLK);
        step(3'd4, 1'b1, 1'b0, 1'b1, 18'h100, 18'h104, 18'h104);
        idle(6);

        for (int u = 0; u < 3; u++) begin
            chk({"drained_", nm[u]}, 32'(exp_q[u].size()), 32'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipe_mux.md
PIPE_MUX -- requirements
Module: pipe_mux

Interface
REQ-001 Parameter WIDTH, default 18: width of each data input and of the output, legal range 1..48.
REQ-002 Parameter INPUTS, default 4: number of data channels, legal range 2..8.
REQ-003 Parameter PIPE, default 1: output pipeline depth, legal range 0..3.
REQ-004 Parameter SELREG, default 1: 1 = select is registered before use; 0 = select is used combinationally.
REQ-005 Parameter OOR_MODE, default 0: response to an out-of-range select; 0 = zero, 1 = hold last in-range result.
REQ-006 Localparam SELW SHALL be max(1, $clog2(INPUTS)).
REQ-007 CLK  input  1  single clock; all registers are rising-edge.
REQ-008 RST  input  1  asynchronous, active-high reset.
REQ-009 CE  input  1  clock enable for every register in the block.
REQ-010 in_bus  input  WIDTH*INPUTS  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 sel  input  SELW  channel select.
REQ-012 in_valid  input  1  qualifies the current in_bus/sel.
REQ-013 err_clr  input  1  synchronous clear for sel_err.
REQ-014 dout  output  WIDTH  selected data after the pipeline.
REQ-015 dout_valid  output  1  in_valid delayed in step with dout.
REQ-016 sel_err  output  1  sticky flag: an out-of-range select was used.

Function
REQ-017 The effective select SHALL be sel_q (the registered sel) when SELREG=1, else sel.
REQ-018 The effective select SHALL be out of range when it is >= INPUTS; this can only occur when INPUTS is not a power of 2.
REQ-019 mux_y SHALL be channel[effective select] when in range; when out of range it SHALL be 0 (OOR_MODE=0) or last_good (OOR_MODE=1).
REQ-020 last_good SHALL load mux_y on each CE cycle with an in-range select; otherwise it holds.
REQ-021 The data path SHALL be mux_y followed by PIPE register stages; PIPE=0 gives dout = mux_y combinationally.
REQ-022 Latency SHALL be PIPE cycles from in_bus to dout, and SELREG+PIPE cycles from sel to dout.
REQ-023 in_valid SHALL pass through a PIPE-deep shift register that is aligned with the data, so dout_valid marks the dout of the same input cycle.
REQ-024 When SELREG=1, in_valid SHALL be delayed one extra stage (total SELREG+PIPE) so that dout_valid matches the select that produced dout.
REQ-025 On a CE cycle where in_valid=1 and the effective select is out of range, sel_err SHALL be set on the next edge.
REQ-026 err_clr=1 on a CE cycle SHALL clear sel_err; if a new error is detected in the same cycle, set SHALL win.
REQ-027 CE=0 SHALL freeze all registers (sel_q, pipeline, valid chain, last_good, sel_err); combinational paths stay live.
REQ-028 Out-of-range selects with in_valid=0 SHALL NOT set sel_err but SHALL still drive mux_y per REQ-019.
REQ-029 No arithmetic is performed; dout SHALL be bit-exact to the selected channel or to the substitute value.

Reset
REQ-030 RST=1 SHALL asynchronously clear sel_q, every pipeline stage, the valid chain, last_good and sel_err to 0, independent of CE and CLK.
REQ-031 After release, dout_valid SHALL stay 0 until a valid input has traversed the full latency.
REQ-032 Reset asserted mid-stream SHALL discard all in-flight data; no stale dout_valid=1 may appear after release.

Verification
REQ-033 INPUTS=4, PIPE=2, SELREG=1: sel 0..3 with channel k = 0x100+k and in_valid=1 -> dout = 0x100+k exactly 3 cycles after each sel, with dout_valid aligned.
REQ-034 INPUTS=5, OOR_MODE=0: sel=6 with in_valid=1 -> dout=0 after the latency; sel_err=1 one edge later and stays 1 until err_clr.
REQ-035 INPUTS=5, OOR_MODE=1: sel=2 (channel 2 = 0xABC), then sel=7 -> dout keeps 0xABC; sel_err sets.
REQ-036 err_clr=1 in the same cycle as a new out-of-range valid select -> sel_err remains 1; err_clr alone -> sel_err=0 next edge.
REQ-037 PIPE=3: CE=0 for 4 cycles mid-stream -> dout and dout_valid frozen; the sequence resumes without loss or duplication when CE returns to 1.
REQ-038 RST pulsed between clock edges with the pipeline full -> dout=0, dout_valid=0 and sel_err=0 immediately; first valid output appears SELREG+PIPE cycles after the first valid input.
